// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and reset-divisor macro for baud_tick_gen
`ifndef UART_DEF_DIV
`define UART_DEF_DIV(clk_hz, baud, os) ((clk_hz) / ((baud) * (os)))
`endif

package uart_pkg;
   localparam int DIV_W_DEF      = 16;
   localparam int OVERSAMPLE_DEF = 16;
   localparam int FRAC_W         = 4;
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: programmable oversample/bit tick generator; UART_BAUD_FRAC_DIV_EN adds fractional divisor
module baud_tick_gen
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DIV_W      = DIV_W_DEF,
   parameter int DEF_DIV    = `UART_DEF_DIV(CLK_HZ, BAUD, OVERSAMPLE)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              div_load,
   input  logic [DIV_W-1:0]  div_value,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              resync,
   output logic              tick,
   output logic              baud_tick,
   output logic              baud_clk
);
   localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   logic [DIV_W-1:0] div_q, div_d, clk_cnt_q, clk_cnt_d, d_eff, term;
   logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
   logic             tick_q, tick_d, baud_tick_q, baud_tick_d, baud_clk_q, baud_clk_d;
   logic             adv;
`ifdef UART_BAUD_FRAC_DIV_EN
   logic [FRAC_W:0]   frac_acc_q, frac_acc_d;
   logic [FRAC_W-1:0] frac_q, frac_d;
`else
   logic unused_frac;
   assign unused_frac = ^div_frac;
`endif

   // tick counter: terminal count stretches by one clock after a fractional carry
   always_comb begin
      d_eff = (div_q == '0) ? DIV_W'(1) : div_q;
`ifdef UART_BAUD_FRAC_DIV_EN
      term       = frac_acc_q[FRAC_W] ? d_eff : d_eff - 1'b1;
      adv        = enable && !div_load && !resync && clk_cnt_q == term;
      frac_d     = div_load ? div_frac : frac_q;
      frac_acc_d = resync ? '0 : adv ? {1'b0, frac_acc_q[FRAC_W-1:0]} + {1'b0, frac_q} : frac_acc_q;
`else
      term = d_eff - 1'b1;
      adv  = enable && !div_load && !resync && clk_cnt_q == term;
`endif
      div_d     = div_load ? div_value : div_q;
      clk_cnt_d = (div_load || resync || adv) ? '0 : enable ? clk_cnt_q + 1'b1 : clk_cnt_q;
   end

   // bit phase and strobes: a control cycle never strobes, disabled cycles hold phase
   always_comb begin
      tick_d      = adv;
      baud_tick_d = adv && os_cnt_q == OS_W'(OVERSAMPLE - 1);
      os_cnt_d    = resync ? '0 : !adv ? os_cnt_q : baud_tick_d ? '0 : os_cnt_q + 1'b1;
      baud_clk_d  = resync ? 1'b0 : adv ? ~baud_clk_q : baud_clk_q;
   end

   // state registers
   always_ff @(posedge clock) begin
      if (reset) begin
         div_q       <= DIV_W'(DEF_DIV);
         clk_cnt_q   <= '0;
         os_cnt_q    <= '0;
         tick_q      <= 1'b0;
         baud_tick_q <= 1'b0;
         baud_clk_q  <= 1'b0;
`ifdef UART_BAUD_FRAC_DIV_EN
         frac_q      <= '0;
         frac_acc_q  <= '0;
`endif
      end else begin
         div_q       <= div_d;
         clk_cnt_q   <= clk_cnt_d;
         os_cnt_q    <= os_cnt_d;
         tick_q      <= tick_d;
         baud_tick_q <= baud_tick_d;
         baud_clk_q  <= baud_clk_d;
`ifdef UART_BAUD_FRAC_DIV_EN
         frac_q      <= frac_d;
         frac_acc_q  <= frac_acc_d;
`endif
      end
   end

   assign tick      = tick_q;
   assign baud_tick = baud_tick_q;
   assign baud_clk  = baud_clk_q;
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: directed checks of tick/baud_tick/baud_clk timing
module tb_baud_tick_gen;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        div_load = 1'b0;
   logic [15:0] div_value = '0;
   logic [3:0]  div_frac = '0;
   logic        resync = 1'b0;
   logic        tick, baud_tick, baud_clk;
   int          checks = 0;
   int          failures = 0;
   int          n, m, cnt;

   baud_tick_gen dut (
      .clock(clock), .reset(reset), .enable(enable), .div_load(div_load),
      .div_value(div_value), .div_frac(div_frac), .resync(resync),
      .tick(tick), .baud_tick(baud_tick), .baud_clk(baud_clk)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // counts falling edges until the selected event: 0 tick, 1 baud_tick, 2 baud_clk change
   task automatic wait_ev(input int which, output int k);
      logic prev;
      logic hit;
      prev = baud_clk;
      k = 0;
      hit = 1'b0;
      while (!hit && k < 20000) begin
         @(negedge clock);
         k++;
         hit = (which == 0) ? tick : (which == 1) ? baud_tick : (baud_clk != prev);
      end
   endtask

   // one-cycle control pulse; returns at the falling edge after the control edge
   task automatic pulse(input logic ld, input logic rs, input logic [15:0] v, input logic [3:0] f);
      div_load = ld;
      resync = rs;
      div_value = v;
      div_frac = f;
      @(negedge clock);
      div_load = 1'b0;
      resync = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clock);
      check("rst_tick", {31'b0, tick}, 0);
      check("rst_baud_tick", {31'b0, baud_tick}, 0);
      check("rst_baud_clk", {31'b0, baud_clk}, 0);
      enable = 1'b1;
      reset = 1'b0;
      wait_ev(0, n);
      check("def_first_tick", n, 325);
      check("def_first_baud_clk", {31'b0, baud_clk}, 1);
      wait_ev(0, n);
      check("def_tick_period", n, 325);
      wait_ev(1, n);
      wait_ev(1, n);
      check("def_baud_period", n, 5200);
      wait_ev(2, n);
      wait_ev(2, n);
      wait_ev(2, m);
      check("def_baud_clk_period", n + m, 650);

      repeat (100) @(negedge clock);
      pulse(1, 0, 16'd4, 4'd0);
      wait_ev(0, n);
      check("d4_first_tick", n, 4);
      wait_ev(0, n);
      check("d4_tick_period", n, 4);
      wait_ev(1, n);
      wait_ev(1, n);
      check("d4_baud_period", n, 64);

      pulse(1, 0, 16'd0, 4'd0);
      wait_ev(0, n);
      check("d0_first_tick", n, 1);
      wait_ev(0, n);
      check("d0_tick_period", n, 1);
      wait_ev(1, n);
      wait_ev(1, n);
      check("d0_baud_period", n, 16);
      pulse(1, 0, 16'd1, 4'd0);
      wait_ev(0, n);
      check("d1_first_tick", n, 1);
      wait_ev(1, n);
      wait_ev(1, n);
      check("d1_baud_period", n, 16);

      pulse(1, 0, 16'd4, 4'd0);
      repeat (2) @(negedge clock);
      enable = 1'b0;
      m = {31'b0, baud_clk};
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         cnt += tick + baud_tick;
      end
      check("dis_no_strobes", cnt, 0);
      check("dis_baud_clk_hold", {31'b0, baud_clk}, m);
      enable = 1'b1;
      wait_ev(0, n);
      check("dis_resume_tick", n, 2);

      pulse(0, 1, 16'd0, 4'd0);
      for (int i = 0; i < 7; i++) wait_ev(0, n);
      check("pre_resync_baud_clk", {31'b0, baud_clk}, 1);
      @(negedge clock);
      pulse(0, 1, 16'd0, 4'd0);
      check("resync_baud_clk", {31'b0, baud_clk}, 0);
      wait_ev(1, n);
      check("resync_baud_latency", n, 64);

      pulse(1, 1, 16'd10, 4'd8);
      wait_ev(0, n);
      check("frac_first_tick", n, 10);
      wait_ev(0, n);
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         wait_ev(0, n);
         cnt += n;
      end
`ifdef UART_BAUD_FRAC_DIV_EN
      check("frac_16_ticks", cnt, 168);
`else
      check("frac_16_ticks", cnt, 160);
`endif

      pulse(0, 0, 16'd0, 4'd0);
      reset = 1'b1;
      @(negedge clock);
      check("rerst_tick", {31'b0, tick}, 0);
      check("rerst_baud_clk", {31'b0, baud_clk}, 0);
      reset = 1'b0;
      wait_ev(0, n);
      check("rerst_div_default", n, 325);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
